// File: rtl/pipelined_tree_adder.sv
// -----------------------------------------------------------------------------
// pipelined_tree_adder
//
// Reduces INPUTS_AMOUNT signed P-bit operands to one P-bit sum through a binary
// adder tree. Odd-width layers pass their last element straight through. A
// register bank follows every REG_EVERY-th layer, and the final stage is always
// registered. Every addition wraps modulo 2^P. With ACCUMULATE=1, the final
// stage adds tree results across the beats of a packet. It emits one sum per
// packet, on the beat that carries in_last.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   inputs     INPUTS_AMOUNT signed P-bit operands
//   in_valid   operands valid this cycle
//   in_last    last beat of a packet (used only when ACCUMULATE=1)
//   in_ready   a beat is accepted when in_valid && in_ready
//   sum        signed P-bit result
//   out_valid  sum is valid
//   out_ready  downstream accepts sum
// -----------------------------------------------------------------------------
module pipelined_tree_adder #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int P             = 16,
  parameter int REG_EVERY     = 1,
  parameter int ACCUMULATE    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [P-1:0] inputs [INPUTS_AMOUNT],
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic signed [P-1:0] sum,
  output logic                out_valid,
  input  logic                out_ready
);

  if (INPUTS_AMOUNT < 1) begin : g_bad_inputs
    $fatal(1, "pipelined_tree_adder: INPUTS_AMOUNT must be >= 1");
  end
  if (REG_EVERY < 1) begin : g_bad_reg_every
    $fatal(1, "pipelined_tree_adder: REG_EVERY must be >= 1");
  end

  typedef logic signed [P-1:0] word_t;

  localparam int N      = (INPUTS_AMOUNT > 0) ? INPUTS_AMOUNT : 1;
  localparam int R      = (REG_EVERY > 0) ? REG_EVERY : 1;
  localparam int L      = (N > 1) ? $clog2(N) : 0;
  localparam int S      = (L == 0) ? 1 : (L + R - 1) / R;
  // Banks between stages; the last stage is the output register itself.
  localparam int NB     = (S > 1) ? S - 1 : 1;
  localparam int LAST_B = (S > 1) ? S - 2 : 0;

  // Number of live elements entering layer k.
  function automatic int layer_width(input int k);
    int w;
    w = N;
    for (int j = 0; j < k; j++) w = (w + 1) / 2;
    return w;
  endfunction

  word_t bank_d [NB][N];
  logic  bank_v [NB];
  logic  bank_l [NB];
  word_t seg_d  [S][N];   // combinational output of each stage's layers

  logic  enable;
  logic  fin_v;
  logic  fin_l;
  word_t tree_res;
  word_t acc;
  word_t total;

  // Global stall: the whole pipe moves only when the output slot is free or
  // being drained this cycle.
  assign enable   = !out_valid || out_ready;
  assign in_ready = enable;

  // Adder layers, grouped into the segment that each pipeline stage covers.
  always_comb begin
    word_t cur [2*N];
    word_t nxt [2*N];
    int    w;
    w = 0;
    for (int s = 0; s < S; s++) begin
      // NOTE: scratch arrays are cleared before use so that every path
      // assigns them and no latch is inferred. The upper half only keeps
      // the pairwise index 2i+1 within range.
      for (int i = 0; i < 2*N; i++) cur[i] = '0;
      for (int i = 0; i < N; i++)
        cur[i] = (s == 0) ? inputs[i] : bank_d[(s == 0) ? 0 : s - 1][i];
      for (int k = s * R; k < (s + 1) * R && k < L; k++) begin
        w = layer_width(k);
        for (int i = 0; i < 2*N; i++) nxt[i] = '0;
        for (int i = 0; i < N; i++) begin
          if (2*i + 1 < w)  nxt[i] = cur[2*i] + cur[2*i + 1];
          else if (2*i < w) nxt[i] = cur[2*i];   // odd tail passes through
        end
        // NOTE: blocking assignments here, because each layer must see the
        // previous layer's value within the same evaluation.
        cur = nxt;
      end
      for (int i = 0; i < N; i++) seg_d[s][i] = cur[i];
    end
  end

  // Control side of the inter-stage banks: valid and last must clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NB; s++) begin
        bank_v[s] <= 1'b0;
        bank_l[s] <= 1'b0;
      end
    end else if (enable) begin
      for (int s = 0; s < S - 1; s++) begin
        bank_v[s] <= (s == 0) ? in_valid : bank_v[(s == 0) ? 0 : s - 1];
        bank_l[s] <= (s == 0) ? in_last  : bank_l[(s == 0) ? 0 : s - 1];
      end
    end
  end

  // NOTE: the data banks have no reset. Their valid bit qualifies them, so
  // stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (enable) begin
      for (int s = 0; s < S - 1; s++)
        for (int i = 0; i < N; i++) bank_d[s][i] <= seg_d[s][i];
    end
  end

  assign fin_v    = (S > 1) ? bank_v[LAST_B] : in_valid;
  assign fin_l    = (S > 1) ? bank_l[LAST_B] : in_last;
  assign tree_res = seg_d[S-1][0];
  assign total    = acc + tree_res;

  // Output stage. In accumulate mode, a beat that is not last only updates acc.
  // sum moves only on a real result, so it stays stable across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      acc       <= '0;
    end else if (enable) begin
      if (ACCUMULATE == 0) begin
        out_valid <= fin_v;
        if (fin_v) sum <= tree_res;
      end else if (fin_v) begin
        if (fin_l) begin
          sum       <= total;
          out_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc       <= total;
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // in_last has no effect in per-beat mode.
  logic unused_last;
  assign unused_last = fin_l;

endmodule

// File: tb/tb_pipelined_tree_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_tree_adder
//
// Five instances cover the parameter corners:
//   u_n8    N=8, P=16, REG_EVERY=1       latency 3, streaming with backpressure
//   u_n5    N=5, P=16, REG_EVERY=2       odd widths, latency 2
//   u_n5w   N=5, P=8,  REG_EVERY=2       wrap-around
//   u_acc   N=4, P=16, ACCUMULATE=1      packets and mid-packet reset
//   u_n1    N=1                          single operand, latency 1
// Expected sums come from plain modular addition of all operands. Packet
// totals come from a running sum.
// Inputs are driven, and outputs sampled, on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipelined_tree_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- u_n8 ----------------
  logic signed [15:0] a_in [8];
  logic a_iv, a_ir, a_ov, a_or;
  logic signed [15:0] a_sum;
  pipelined_tree_adder #(.INPUTS_AMOUNT(8), .P(16), .REG_EVERY(1), .ACCUMULATE(0)) u_n8 (
    .clk(clk), .rst(rst), .inputs(a_in), .in_valid(a_iv), .in_last(1'b0),
    .in_ready(a_ir), .sum(a_sum), .out_valid(a_ov), .out_ready(a_or));

  // ---------------- u_n5 ----------------
  logic signed [15:0] b_in [5];
  logic b_iv, b_ir, b_ov, b_or;
  logic signed [15:0] b_sum;
  pipelined_tree_adder #(.INPUTS_AMOUNT(5), .P(16), .REG_EVERY(2), .ACCUMULATE(0)) u_n5 (
    .clk(clk), .rst(rst), .inputs(b_in), .in_valid(b_iv), .in_last(1'b0),
    .in_ready(b_ir), .sum(b_sum), .out_valid(b_ov), .out_ready(b_or));

  // ---------------- u_n5w ----------------
  logic signed [7:0] c_in [5];
  logic c_iv, c_ir, c_ov, c_or;
  logic signed [7:0] c_sum;
  pipelined_tree_adder #(.INPUTS_AMOUNT(5), .P(8), .REG_EVERY(2), .ACCUMULATE(0)) u_n5w (
    .clk(clk), .rst(rst), .inputs(c_in), .in_valid(c_iv), .in_last(1'b0),
    .in_ready(c_ir), .sum(c_sum), .out_valid(c_ov), .out_ready(c_or));

  // ---------------- u_n1 ----------------
  logic signed [15:0] d_in [1];
  logic d_iv, d_ir, d_ov, d_or;
  logic signed [15:0] d_sum;
  pipelined_tree_adder #(.INPUTS_AMOUNT(1), .P(16), .REG_EVERY(1), .ACCUMULATE(0)) u_n1 (
    .clk(clk), .rst(rst), .inputs(d_in), .in_valid(d_iv), .in_last(1'b0),
    .in_ready(d_ir), .sum(d_sum), .out_valid(d_ov), .out_ready(d_or));

  // ---------------- u_acc ----------------
  logic signed [15:0] e_in [4];
  logic e_iv, e_il, e_ir, e_ov, e_or;
  logic signed [15:0] e_sum;
  pipelined_tree_adder #(.INPUTS_AMOUNT(4), .P(16), .REG_EVERY(1), .ACCUMULATE(1)) u_acc (
    .clk(clk), .rst(rst), .inputs(e_in), .in_valid(e_iv), .in_last(e_il),
    .in_ready(e_ir), .sum(e_sum), .out_valid(e_ov), .out_ready(e_or));

  task automatic set_acc(input int v0, input int v1, input int v2, input int v3, input logic last);
    e_in[0] = 16'(v0);
    e_in[1] = 16'(v1);
    e_in[2] = 16'(v2);
    e_in[3] = 16'(v3);
    e_iv    = 1'b1;
    e_il    = last;
  endtask

  // Random beats into u_n8 while out_ready follows 1,0,0,1. A scoreboard holds
  // the expected sums in input order.
  task automatic run_stream(input int beats);
    logic signed [15:0] q [$];
    logic signed [15:0] s;
    logic signed [15:0] held;
    bit stalled;
    int sent, guard, cyc;
    stalled = 0; sent = 0; guard = 0; cyc = 0; held = '0;
    while ((sent < beats || q.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (stalled) begin
        check("stall_valid_held", a_ov, 1'b1);
        check("stall_sum_held", a_sum, held);
      end
      a_or = (cyc % 4 == 0) || (cyc % 4 == 3);
      a_iv = (sent < beats);
      s = '0;
      foreach (a_in[i]) begin
        a_in[i] = 16'($urandom);
        s += a_in[i];
      end
      #1;
      check("stream_in_ready", a_ir, !a_ov || a_or);
      if (a_ov && a_or) begin
        if (q.size() == 0) check("stream_extra_output", a_ov, 1'b0);
        else               check("stream_sum", a_sum, q.pop_front());
      end
      if (a_iv && a_ir) begin
        q.push_back(s);
        sent++;
      end
      stalled = a_ov && !a_or;
      held    = a_sum;
      cyc++;
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    check("stream_all_sent", sent, beats);
    check("stream_drained", q.size(), 0);
  endtask

  // Random packets into u_acc with random backpressure. Each packet's total is
  // queued when its last beat is accepted.
  task automatic run_acc_stream(input int beats);
    logic signed [15:0] q [$];
    logic signed [15:0] run;
    logic signed [15:0] bs;
    int sent, guard;
    run = '0; sent = 0; guard = 0;
    while ((sent < beats || q.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
      e_or = 1'($urandom_range(0, 1));
      e_iv = (sent < beats) && ($urandom_range(0, 3) != 0);
      e_il = (sent == beats - 1) || ($urandom_range(0, 2) == 0);
      bs = '0;
      foreach (e_in[i]) begin
        e_in[i] = 16'($urandom);
        bs += e_in[i];
      end
      #1;
      check("acc_in_ready", e_ir, !e_ov || e_or);
      if (e_ov && e_or) begin
        if (q.size() == 0) check("acc_extra_output", e_ov, 1'b0);
        else               check("acc_packet_sum", e_sum, q.pop_front());
      end
      if (e_iv && e_ir) begin
        sent++;
        run += bs;
        if (e_il) begin
          q.push_back(run);
          run = '0;
        end
      end
    end
    e_iv = 1'b0;
    e_il = 1'b0;
    e_or = 1'b1;
    check("acc_all_sent", sent, beats);
    check("acc_drained", q.size(), 0);
  endtask

  int n1_vals [4] = '{-7, 3, 32767, -32768};

  initial begin
    rst = 1'b0;
    a_iv = 0; b_iv = 0; c_iv = 0; d_iv = 0; e_iv = 0; e_il = 0;
    a_or = 1; b_or = 1; c_or = 1; d_or = 1; e_or = 1;
    foreach (a_in[i]) a_in[i] = '0;
    foreach (b_in[i]) b_in[i] = '0;
    foreach (c_in[i]) c_in[i] = '0;
    foreach (d_in[i]) d_in[i] = '0;
    foreach (e_in[i]) e_in[i] = '0;
    #1 rst = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", a_ov, 1'b0);
    check("rst_sum", a_sum, 0);
    check("rst_acc_out_valid", e_ov, 1'b0);
    check("rst_acc_sum", e_sum, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", a_ir, 1'b1);
    check("rst_acc_in_ready", e_ir, 1'b1);

    // N=8 with operands 1..8 gives 36, three cycles after acceptance.
    @(negedge clk);
    foreach (a_in[i]) a_in[i] = 16'(i + 1);
    a_iv = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      a_iv = 1'b0;
      check($sformatf("n8_valid_cycle%0d", c), a_ov, (c == 3));
    end
    check("n8_sum", a_sum, 36);

    // N=5, REG_EVERY=2: 55 after two cycles. In parallel, P=8 wraps to -128.
    @(negedge clk);
    b_in = '{-16'sd3, 16'sd7, 16'sd100, -16'sd50, 16'sd1};
    c_in = '{8'sd127, 8'sd1, 8'sd0, 8'sd0, 8'sd0};
    b_iv = 1'b1;
    c_iv = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      b_iv = 1'b0;
      c_iv = 1'b0;
      check($sformatf("n5_valid_cycle%0d", c), b_ov, (c == 2));
      check($sformatf("n5w_valid_cycle%0d", c), c_ov, (c == 2));
    end
    check("n5_sum", b_sum, 55);
    check("n5w_wrap_sum", c_sum, -128);

    // N=1: each operand comes back one cycle later, and in_ready stays high.
    @(negedge clk);
    d_in[0] = 16'(n1_vals[0]);
    d_iv = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("n1_valid", d_ov, 1'b1);
      check("n1_sum", d_sum, n1_vals[c]);
      check("n1_in_ready", d_ir, 1'b1);
      if (c < 3) d_in[0] = 16'(n1_vals[c + 1]);
      else       d_iv = 1'b0;
    end

    // Accumulate: {1}x4, {2}x4, {3}x4+last gives 24. The next single-beat
    // packet {5,0,0,0}+last gives 5.
    @(negedge clk);
    set_acc(1, 1, 1, 1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0)      set_acc(2, 2, 2, 2, 1'b0);
      else if (c == 1) set_acc(3, 3, 3, 3, 1'b1);
      else if (c == 2) set_acc(5, 0, 0, 0, 1'b1);
      else begin
        e_iv = 1'b0;
        e_il = 1'b0;
      end
      check($sformatf("acc_valid_cycle%0d", c), e_ov, (c == 3 || c == 4));
      if (c == 3) check("acc_packet_24", e_sum, 24);
      if (c == 4) check("acc_single_beat_5", e_sum, 5);
    end

    // Reset mid-packet. One beat is already in acc and a second is in flight.
    @(negedge clk);
    set_acc(1, 1, 1, 1, 1'b0);
    @(negedge clk);
    set_acc(2, 2, 2, 2, 1'b0);
    @(negedge clk);
    e_iv = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", e_ov, 1'b0);
    check("midrst_sum", e_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_acc(1, 0, 0, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) set_acc(1, 0, 0, 0, 1'b1);
      else begin
        e_iv = 1'b0;
        e_il = 1'b0;
      end
      check($sformatf("postrst_valid_cycle%0d", c), e_ov, (c == 2));
      if (c == 2) check("postrst_sum", e_sum, 2);
    end

    // Randomised streaming with backpressure.
    run_stream(60);
    run_acc_stream(80);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
